rtp_engine_regmap_mc: RTL and testbench
=======================================

// Module: rtp_engine_regmap_mc
// PURPOSE
//  Multi-channel register map for the RTP engine: NUM_CHANNELS independent RTP streams behind one up_* bus.
//  Per channel: sequence-number seed, self-clearing start/stop pulses and an active flag.
//  Per channel: write-triggered snapshot of the seven header/data monitor words, so software reads a coherent set.
//  Sits between the AXI-to-up bridge and the per-channel rtp_engine packetizers.
// PARAMETERS
//  VERSION       32'h0002_0000  value returned at 0x000
//  ID            0              core instance id, returned at 0x001
//  NUM_CHANNELS  2              number of RTP channels, legal 1..8
// PORTS
//  up_clk          in   1        register clock, the only clock of the block
//  up_rst          in   1        reset, synchronous to up_clk, active-high
//  seq_number_h    out  16*NC    ch n at [16n+:16] = SEQ[n][31:16], RTP payload-header extended seq
//  seq_number_l    out  16*NC    ch n at [16n+:16] = SEQ[n][15:0], RTP header seq
//  start_transfer  out  NC       one-cycle start pulse per channel
//  stop_transfer   out  NC       one-cycle stop pulse per channel
//  transfer_active out  NC       level, channel started and not yet stopped
//  f_32b_rtp_h, m_32b_rtp_h, l_32b_rtp_h  in  32*NC  first/middle/last RTP header word, ch n at [32n+:32]
//  f_32b_rtpp_h, l_32b_rtpp_h             in  32*NC  first/last RTP payload-header word
//  f_32b_tdata, l_32b_tdata               in  32*NC  first/last stream data word
//  up_wreq / up_waddr[13:0] / up_wdata[31:0]  in   write request, address and data
//  up_wack                                    out  write ack
//  up_rreq / up_raddr[13:0]                   in   read request and address
//  up_rdata[31:0] / up_rack                   out  read data and read ack
// BEHAVIOUR
//  Reset: every register and output = 0. Includes SEQ, SNAP, active, pulses, up_wack, up_rack, up_rdata.
//  up_wack = up_wreq delayed 1 cycle. Write takes effect on the wreq edge.
//  up_rack = up_rreq delayed 1 cycle. up_rdata is valid with up_rack and holds until the next rreq.
//  Global map:
//   0x000 VERSION ro
//   0x001 ID ro
//   0x002 SCRATCH rw
//   0x003 NUM_CHANNELS ro
//   0x004 START_MASK w1p, bit n = start ch n
//   0x005 STOP_MASK w1p
//   0x006 ACTIVE ro, bit n = active[n]; reads of 0x004/0x005 return 0
//  Channel map, base B = 0x010 + 0x10*n:
//   B+0 SEQ rw 32b
//   B+1 CTRL w1p: bit0 start, bit1 stop; reads 0
//   B+2 STATUS ro: bit0 active
//   B+3 SNAP wo: any write captures the seven monitor inputs of ch n
//   B+4..B+A SNAP words ro, order f_rtp_h, m_rtp_h, l_rtp_h, f_rtpp_h, l_rtpp_h, f_tdata, l_tdata
//  Channels n >= NUM_CHANNELS, unmapped offsets and raddr >= 0x090: read 0, writes ignored.
//  Per-channel FSM, IDLE/ACTIVE; start_req/stop_req come from CTRL or MASK writes:
//   IDLE  + start_req            -> ACTIVE; start_transfer[n]=1 the next cycle, for exactly 1 cycle.
//   ACTIVE + stop_req            -> IDLE; stop_transfer[n]=1 the next cycle, for exactly 1 cycle.
//   start_req while ACTIVE, stop_req while IDLE -> no pulse, no state change.
//   start_req and stop_req in the same write (CTRL=0x3) -> stop wins:
//     ACTIVE -> IDLE with stop pulse; IDLE stays IDLE, no pulses.
//   transfer_active[n] = (state==ACTIVE), registered; rises in the same cycle as the start pulse.
//  SEQ writes are accepted in any state; seq_number_* follow SEQ 1 cycle after wreq.
//  Snapshot is taken from the input values sampled on the SNAP wreq cycle. All 7 words load atomically.
//  Snapshot contents hold until the next SNAP write to that channel.
//  A SNAP write and a read of the same channel in one cycle: the read returns the old snapshot.
//  up_rst mid-operation: next cycle all channels IDLE; any in-flight pulse is dropped; no stop pulse is generated.
// TESTING
//  1. Reset, then read 0x000/0x003/0x006 -> VERSION, NUM_CHANNELS (2), 0. Every output is 0.
//  2. Write 0x010=0xDEAD_BEEF -> seq_number_h[15:0]=0xDEAD and seq_number_l[15:0]=0xBEEF 1 cycle later; ch1 outputs still 0.
//  3. Write 0x011=1 -> start_transfer=2'b01 for 1 cycle, ACTIVE reads 1. Repeat the write -> no pulse.
//     Write 0x005=3 -> stop pulse on ch0 only, ACTIVE reads 0.
//  4. Write 0x004=3, then 0x021=3 -> ch1 stop pulse 1 cycle later, ACTIVE=1.
//     Then 0x011=3 with ch0 IDLE (after a stop) -> no pulses.
//  5. Drive ch1 f_32b_rtp_h=0x8060_0001 and write 0x023=1, then change the inputs -> read 0x024 returns 0x8060_0001.
//  6. Start ch0, assert up_rst for 1 cycle -> transfer_active=0, no stop pulse. Read 0x150 -> 0, rack still 1 cycle after rreq.

Source files
------------

// File: rtl/rtp_engine_regmap_mc.sv
// Multi-channel RTP engine register map: per-channel sequence seed, start/stop
// control with an IDLE/ACTIVE state per channel, and coherent monitor snapshots.
module rtp_engine_regmap_mc #(
  parameter logic [31:0] VERSION      = 32'h0002_0000,
  parameter logic [31:0] ID           = 32'd0,
  parameter int          NUM_CHANNELS = 2
) (
  input  logic                      up_clk,
  input  logic                      up_rst,
  output logic [16*NUM_CHANNELS-1:0] seq_number_h,
  output logic [16*NUM_CHANNELS-1:0] seq_number_l,
  output logic [NUM_CHANNELS-1:0]    start_transfer,
  output logic [NUM_CHANNELS-1:0]    stop_transfer,
  output logic [NUM_CHANNELS-1:0]    transfer_active,
  input  logic [32*NUM_CHANNELS-1:0] f_32b_rtp_h,
  input  logic [32*NUM_CHANNELS-1:0] m_32b_rtp_h,
  input  logic [32*NUM_CHANNELS-1:0] l_32b_rtp_h,
  input  logic [32*NUM_CHANNELS-1:0] f_32b_rtpp_h,
  input  logic [32*NUM_CHANNELS-1:0] l_32b_rtpp_h,
  input  logic [32*NUM_CHANNELS-1:0] f_32b_tdata,
  input  logic [32*NUM_CHANNELS-1:0] l_32b_tdata,
  input  logic                      up_wreq,
  input  logic [13:0]               up_waddr,
  input  logic [31:0]               up_wdata,
  output logic                      up_wack,
  input  logic                      up_rreq,
  input  logic [13:0]               up_raddr,
  output logic [31:0]               up_rdata,
  output logic                      up_rack
);

  localparam int NC = NUM_CHANNELS;

  typedef enum logic {IDLE, ACTIVE} chan_state_e;

  chan_state_e state [NC];
  chan_state_e state_nxt [NC];

  logic [31:0]   scratch;
  logic [31:0]   seq [NC];
  logic [31:0]   snap [NC][7];
  logic [31:0]   mon [NC][7];
  logic [NC-1:0] start_req, stop_req, seq_req, snap_req;
  logic [NC-1:0] start_nxt, stop_nxt;
  logic          wr_ch_hit, rd_ch_hit;
  logic [3:0]    wr_chan, rd_chan, wr_off, rd_off;
  logic [2:0]    snap_idx;
  logic [31:0]   rd_value;

  // Channel windows start at 0x010; window 0 holds the global registers.
  assign wr_ch_hit = (up_waddr[13:8] == 6'd0) && (up_waddr[7:4] != 4'd0) && (up_waddr[7:4] <= 4'(NC));
  assign rd_ch_hit = (up_raddr[13:8] == 6'd0) && (up_raddr[7:4] != 4'd0) && (up_raddr[7:4] <= 4'(NC));
  assign wr_chan   = up_waddr[7:4] - 4'd1;
  assign rd_chan   = up_raddr[7:4] - 4'd1;
  assign wr_off    = up_waddr[3:0];
  assign rd_off    = up_raddr[3:0];
  assign snap_idx  = 3'(rd_off - 4'd4);

  always_comb begin
    for (int n = 0; n < NC; n++) begin
      mon[n][0] = f_32b_rtp_h[32*n +: 32];
      mon[n][1] = m_32b_rtp_h[32*n +: 32];
      mon[n][2] = l_32b_rtp_h[32*n +: 32];
      mon[n][3] = f_32b_rtpp_h[32*n +: 32];
      mon[n][4] = l_32b_rtpp_h[32*n +: 32];
      mon[n][5] = f_32b_tdata[32*n +: 32];
      mon[n][6] = l_32b_tdata[32*n +: 32];
      seq_number_h[16*n +: 16] = seq[n][31:16];
      seq_number_l[16*n +: 16] = seq[n][15:0];
      transfer_active[n]       = (state[n] == ACTIVE);
    end
  end

  always_comb begin
    start_req = '0;
    stop_req  = '0;
    seq_req   = '0;
    snap_req  = '0;
    for (int n = 0; n < NC; n++) begin
      if (up_wreq) begin
        if (up_waddr == 14'h004) start_req[n] = up_wdata[n];
        if (up_waddr == 14'h005) stop_req[n]  = up_wdata[n];
        if (wr_ch_hit && (wr_chan == 4'(n))) begin
          case (wr_off)
            4'h0: seq_req[n] = 1'b1;
            4'h1: begin
              start_req[n] = up_wdata[0];
              stop_req[n]  = up_wdata[1];
            end
            4'h3: snap_req[n] = 1'b1;
            default: ;
          endcase
        end
      end
    end
  end

  // Stop has priority over a simultaneous start; redundant requests are ignored.
  always_comb begin
    for (int n = 0; n < NC; n++) begin
      state_nxt[n] = state[n];
      start_nxt[n] = 1'b0;
      stop_nxt[n]  = 1'b0;
      if (stop_req[n]) begin
        if (state[n] == ACTIVE) begin
          state_nxt[n] = IDLE;
          stop_nxt[n]  = 1'b1;
        end
      end else if (start_req[n] && (state[n] == IDLE)) begin
        state_nxt[n] = ACTIVE;
        start_nxt[n] = 1'b1;
      end
    end
  end

  always_ff @(posedge up_clk) begin
    for (int n = 0; n < NC; n++) begin
      if (up_rst) state[n] <= IDLE;
      else        state[n] <= state_nxt[n];
    end
  end

  always_comb begin
    rd_value = '0;
    case (up_raddr)
      14'h000: rd_value = VERSION;
      14'h001: rd_value = ID;
      14'h002: rd_value = scratch;
      14'h003: rd_value = 32'(NC);
      14'h006: rd_value[NC-1:0] = transfer_active;
      default: ;
    endcase
    for (int n = 0; n < NC; n++) begin
      if (rd_ch_hit && (rd_chan == 4'(n))) begin
        case (rd_off)
          4'h0: rd_value = seq[n];
          4'h2: rd_value = {31'd0, transfer_active[n]};
          4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA: rd_value = snap[n][snap_idx];
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge up_clk) begin
    if (up_rst) begin
      scratch        <= '0;
      start_transfer <= '0;
      stop_transfer  <= '0;
      up_wack        <= 1'b0;
      up_rack        <= 1'b0;
      up_rdata       <= '0;
      for (int n = 0; n < NC; n++) begin
        seq[n] <= '0;
        for (int k = 0; k < 7; k++) snap[n][k] <= '0;
      end
    end else begin
      start_transfer <= start_nxt;
      stop_transfer  <= stop_nxt;
      up_wack        <= up_wreq;
      up_rack        <= up_rreq;
      if (up_rreq) up_rdata <= rd_value;
      if (up_wreq && (up_waddr == 14'h002)) scratch <= up_wdata;
      for (int n = 0; n < NC; n++) begin
        if (seq_req[n]) seq[n] <= up_wdata;
        if (snap_req[n]) begin
          for (int k = 0; k < 7; k++) snap[n][k] <= mon[n][k];
        end
      end
    end
  end

endmodule

// File: tb/tb_rtp_engine_regmap_mc.sv
// Bench for rtp_engine_regmap_mc: a register-level model checked every cycle,
// plus hand-computed expectations along the directed sequence.
module tb_rtp_engine_regmap_mc;

  localparam int NC = 2;

  logic        up_clk = 1'b0;
  logic        up_rst;
  logic [31:0] seq_number_h, seq_number_l;
  logic [1:0]  start_transfer, stop_transfer, transfer_active;
  logic [63:0] f_rtp_h, m_rtp_h, l_rtp_h, f_rtpp_h, l_rtpp_h, f_tdata, l_tdata;
  logic        up_wreq, up_rreq, up_wack, up_rack;
  logic [13:0] up_waddr, up_raddr;
  logic [31:0] up_wdata, up_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  rtp_engine_regmap_mc #(.VERSION(32'h0002_0000), .ID(32'd0), .NUM_CHANNELS(NC)) dut (
    .up_clk(up_clk), .up_rst(up_rst),
    .seq_number_h(seq_number_h), .seq_number_l(seq_number_l),
    .start_transfer(start_transfer), .stop_transfer(stop_transfer),
    .transfer_active(transfer_active),
    .f_32b_rtp_h(f_rtp_h), .m_32b_rtp_h(m_rtp_h), .l_32b_rtp_h(l_rtp_h),
    .f_32b_rtpp_h(f_rtpp_h), .l_32b_rtpp_h(l_rtpp_h),
    .f_32b_tdata(f_tdata), .l_32b_tdata(l_tdata),
    .up_wreq(up_wreq), .up_waddr(up_waddr), .up_wdata(up_wdata), .up_wack(up_wack),
    .up_rreq(up_rreq), .up_raddr(up_raddr), .up_rdata(up_rdata), .up_rack(up_rack)
  );

  initial forever #5 up_clk = ~up_clk;

  // Register-level model of what software should observe.
  logic [31:0] m_seq [NC]   = '{default: '0};
  logic [31:0] m_snap [NC][7] = '{default: '{default: '0}};
  logic [31:0] m_scratch = '0;
  logic [1:0]  m_act = '0, m_start = '0, m_stop = '0;
  logic        m_wack = 1'b0, m_rack = 1'b0;
  logic [31:0] m_rdata = '0;

  function automatic logic [31:0] mon_word(input int n, input int k);
    case (k)
      0: return f_rtp_h[32*n +: 32];
      1: return m_rtp_h[32*n +: 32];
      2: return l_rtp_h[32*n +: 32];
      3: return f_rtpp_h[32*n +: 32];
      4: return l_rtpp_h[32*n +: 32];
      5: return f_tdata[32*n +: 32];
      default: return l_tdata[32*n +: 32];
    endcase
  endfunction

  function automatic logic [31:0] model_read(input logic [13:0] addr);
    int a, ch, off;
    a = int'(addr);
    if (a == 0) return 32'h0002_0000;
    if (a == 2) return m_scratch;
    if (a == 3) return NC;
    if (a == 6) return {30'd0, m_act};
    if (a >= 16 && a < 16 + 16 * NC) begin
      ch  = a / 16 - 1;
      off = a % 16;
      if (off == 0) return m_seq[ch];
      if (off == 2) return {31'd0, m_act[ch]};
      if (off >= 4 && off <= 10) return m_snap[ch][off-4];
    end
    return 32'd0;
  endfunction

  task automatic model_start(input int ch);
    if (!m_act[ch]) begin
      m_act[ch]   = 1'b1;
      m_start[ch] = 1'b1;
    end
  endtask

  task automatic model_stop(input int ch);
    if (m_act[ch]) begin
      m_act[ch]  = 1'b0;
      m_stop[ch] = 1'b1;
    end
  endtask

  task automatic model_write(input logic [13:0] addr, input logic [31:0] d);
    int a, ch, off;
    a = int'(addr);
    if (a == 2) m_scratch = d;
    else if (a == 4) begin
      for (int n = 0; n < NC; n++) if (d[n]) model_start(n);
    end else if (a == 5) begin
      for (int n = 0; n < NC; n++) if (d[n]) model_stop(n);
    end else if (a >= 16 && a < 16 + 16 * NC) begin
      ch  = a / 16 - 1;
      off = a % 16;
      if (off == 0) m_seq[ch] = d;
      else if (off == 1) begin
        if (d[1]) model_stop(ch);
        else if (d[0]) model_start(ch);
      end else if (off == 3) begin
        for (int k = 0; k < 7; k++) m_snap[ch][k] = mon_word(ch, k);
      end
    end
  endtask

  always @(posedge up_clk) begin
    if (up_rst) begin
      for (int n = 0; n < NC; n++) begin
        m_seq[n] = '0;
        for (int k = 0; k < 7; k++) m_snap[n][k] = '0;
      end
      m_scratch = '0; m_act = '0; m_start = '0; m_stop = '0;
      m_wack = 1'b0; m_rack = 1'b0; m_rdata = '0;
    end else begin
      m_wack  = up_wreq;
      m_rack  = up_rreq;
      if (up_rreq) m_rdata = model_read(up_raddr);
      m_start = '0;
      m_stop  = '0;
      if (up_wreq) model_write(up_waddr, up_wdata);
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Every cycle after the first edge, all outputs must track the model.
  initial begin
    @(posedge up_clk);
    forever begin
      @(negedge up_clk);
      checkOutput("seq_h", 64'(seq_number_h), 64'({m_seq[1][31:16], m_seq[0][31:16]}));
      checkOutput("seq_l", 64'(seq_number_l), 64'({m_seq[1][15:0], m_seq[0][15:0]}));
      checkOutput("start", 64'(start_transfer), 64'(m_start));
      checkOutput("stop", 64'(stop_transfer), 64'(m_stop));
      checkOutput("active", 64'(transfer_active), 64'(m_act));
      checkOutput("wack", 64'(up_wack), 64'(m_wack));
      checkOutput("rack", 64'(up_rack), 64'(m_rack));
      checkOutput("rdata", 64'(up_rdata), 64'(m_rdata));
    end
  end

  // Drives one bus cycle starting at a falling edge; returns at the falling
  // edge after the DUT has sampled it.
  task automatic applyStimulus(input logic w, input logic [13:0] wa, input logic [31:0] wd,
                               input logic r, input logic [13:0] ra);
    up_wreq = w; up_waddr = wa; up_wdata = wd;
    up_rreq = r; up_raddr = ra;
    @(negedge up_clk);
    up_wreq = 1'b0;
    up_rreq = 1'b0;
  endtask

  task automatic writeReg(input logic [13:0] a, input logic [31:0] d);
    applyStimulus(1'b1, a, d, 1'b0, 14'd0);
  endtask

  task automatic readExpect(input string name, input logic [13:0] a, input logic [31:0] exp);
    applyStimulus(1'b0, 14'd0, 32'd0, 1'b1, a);
    checkOutput({name, "_rack"}, 64'(up_rack), 64'd1);
    checkOutput(name, 64'(up_rdata), 64'(exp));
  endtask

  task automatic randomizeMonitors();
    f_rtp_h  = {$urandom, $urandom}; m_rtp_h  = {$urandom, $urandom};
    l_rtp_h  = {$urandom, $urandom}; f_rtpp_h = {$urandom, $urandom};
    l_rtpp_h = {$urandom, $urandom}; f_tdata  = {$urandom, $urandom};
    l_tdata  = {$urandom, $urandom};
  endtask

  initial begin
    up_rst = 1'b1;
    up_wreq = 1'b0; up_waddr = '0; up_wdata = '0;
    up_rreq = 1'b0; up_raddr = '0;
    randomizeMonitors();
    repeat (2) @(negedge up_clk);
    checkOutput("rst_active", 64'(transfer_active), 64'd0);
    checkOutput("rst_rdata", 64'(up_rdata), 64'd0);
    up_rst = 1'b0;
    @(negedge up_clk);

    readExpect("version", 14'h000, 32'h0002_0000);
    readExpect("id", 14'h001, 32'd0);
    readExpect("num_ch", 14'h003, 32'd2);
    readExpect("active0", 14'h006, 32'd0);

    writeReg(14'h010, 32'hDEAD_BEEF);
    checkOutput("seq_h_lit", 64'(seq_number_h), 64'h0000_DEAD);
    checkOutput("seq_l_lit", 64'(seq_number_l), 64'h0000_BEEF);
    writeReg(14'h020, 32'h1234_5678);
    readExpect("seq1", 14'h020, 32'h1234_5678);
    writeReg(14'h002, 32'hA5A5_0F0F);
    readExpect("scratch", 14'h002, 32'hA5A5_0F0F);

    writeReg(14'h011, 32'd1);
    checkOutput("start_lit", 64'(start_transfer), 64'b01);
    readExpect("active_ch0", 14'h006, 32'd1);
    writeReg(14'h011, 32'd1);
    checkOutput("restart_lit", 64'(start_transfer), 64'b00);
    readExpect("status0", 14'h012, 32'd1);
    readExpect("ctrl_reads0", 14'h011, 32'd0);
    writeReg(14'h005, 32'd3);
    checkOutput("stop_lit", 64'(stop_transfer), 64'b01);
    readExpect("active_off", 14'h006, 32'd0);

    writeReg(14'h004, 32'd3);
    checkOutput("start_both", 64'(start_transfer), 64'b11);
    writeReg(14'h021, 32'd3);
    checkOutput("stop_ch1", 64'(stop_transfer), 64'b10);
    readExpect("active_ch0_only", 14'h006, 32'd1);
    writeReg(14'h011, 32'd3);
    checkOutput("stop_ch0", 64'(stop_transfer), 64'b01);
    writeReg(14'h011, 32'd3);
    checkOutput("idle_both_stop", 64'(stop_transfer), 64'b00);
    checkOutput("idle_both_start", 64'(start_transfer), 64'b00);
    writeReg(14'h005, 32'd3);

    writeReg(14'h030, 32'hFFFF_FFFF);
    writeReg(14'h0A0, 32'hFFFF_FFFF);
    readExpect("unmapped_ch", 14'h030, 32'd0);
    readExpect("unmapped_off", 14'h01F, 32'd0);

    f_rtp_h[63:32] = 32'h8060_0001;
    writeReg(14'h023, 32'd1);
    randomizeMonitors();
    readExpect("snap_f_rtp", 14'h024, 32'h8060_0001);
    for (int a = 14'h025; a <= 14'h02A; a++) applyStimulus(1'b0, 14'd0, 32'd0, 1'b1, 14'(a));
    f_rtp_h[63:32] = 32'h1357_9BDF;
    applyStimulus(1'b1, 14'h023, 32'd0, 1'b1, 14'h024);
    checkOutput("snap_old_on_collide", 64'(up_rdata), 64'h8060_0001);
    readExpect("snap_new", 14'h024, 32'h1357_9BDF);

    writeReg(14'h011, 32'd1);
    checkOutput("start_before_rst", 64'(start_transfer), 64'b01);
    up_rst = 1'b1;
    @(negedge up_clk);
    up_rst = 1'b0;
    checkOutput("rst_active_mid", 64'(transfer_active), 64'd0);
    checkOutput("rst_no_stop", 64'(stop_transfer), 64'd0);
    checkOutput("rst_seq", 64'(seq_number_l), 64'd0);
    @(negedge up_clk);
    checkOutput("rst_no_stop_later", 64'(stop_transfer), 64'd0);
    readExpect("out_of_range", 14'h150, 32'd0);
    readExpect("snap_cleared", 14'h024, 32'd0);

    repeat (2) @(negedge up_clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
